hack_alu_pipe: RTL and testbench
================================

// Module: hack_alu_pipe
// PURPOSE
//  Parametrised, pipelined successor to the team's AND/OR/NAND gate bank: a Hack-style ALU.
//  Built from the same logic primitives, generalised to WIDTH bits, with the six Hack control bits.
//  Two register stages, each guarded by a valid/ready handshake so upstream and downstream can stall.
//  Sits between the CPU operand mux and the D/A/M write-back path.
// PARAMETERS
//  WIDTH  16  operand/result width in bits (>=2)
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operands/ctrl valid this cycle
//  in_ready   out  1      block accepts input this cycle
//  x          in   WIDTH  operand x
//  y          in   WIDTH  operand y
//  ctrl       in   6      {zx,nx,zy,ny,f,no}, ctrl[5]=zx
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts result
//  out        out  WIDTH  ALU result
//  zr         out  1      out == 0
//  ng         out  1      out[WIDTH-1]
// BEHAVIOUR
//  - Reset (rst_n=0, async): stage valids v1,v2 clear; out, zr, ng clear to 0; out_valid=0.
//    Any in-flight data is discarded. Release is synchronous to clk.
//  - Handshake: a transfer occurs on a cycle with valid&ready high at the clk edge.
//    out, zr and ng hold stable while out_valid=1 and out_ready=0.
//  - Ready chain (combinational):
//    s2_rdy = !v2 | out_ready; s1_rdy = !v1 | s2_rdy; in_ready = s1_rdy.
//    in_ready must not depend on in_valid.
//  - Stage 1 loads when in_valid & s1_rdy:
//    xa = zx ? 0 : x;  xp = nx ? ~xa : xa;
//    ya = zy ? 0 : y;  yp = ny ? ~ya : ya;
//    registers xp, yp, f, no; v1 <= 1.
//    If s1_rdy & !in_valid then v1 <= 0.
//  - Stage 2 loads when v1 & s2_rdy:
//    r = f ? (xp + yp) mod 2^WIDTH : (xp & yp);  out <= no ? ~r : r;
//    zr <= (final out == 0); ng <= final out[WIDTH-1]; v2 <= 1.
//    If s2_rdy & !v1 then v2 <= 0, and out/zr/ng hold their last values.
//  - out_valid = v2.
//  - Latency 2 cycles from input handshake to out_valid with no stall.
//    Throughput 1 result/cycle while out_ready=1.
//  - Arithmetic: unsigned WIDTH-bit add; carry out is discarded; no overflow flag.
//  - Full pipe (v1=v2=1) with out_ready=0: in_ready=0 and nothing advances.
//    When out_ready rises, stage 2 transfer, stage 2 refill from stage 1 and stage 1 refill
//    from input all happen on the same edge.
//  - Ordering: results leave in input order; no drop, no duplication.
// TESTING (WIDTH=16, out_ready=1 unless stated)
//  1 Const: ctrl 101010 -> out 0x0000 zr=1; 111111 -> 0x0001; 111010 -> 0xFFFF ng=1; each at +2 cycles.
//  2 Arith: x=5,y=3: 000010 -> 8; 010011 -> 2; 000111 -> 0xFFFE ng=1; 000000 -> 1; 010101 -> 7.
//  3 Wrap: x=0x7FFF,y=1,ctrl 000010 -> 0x8000 ng=1; x=0xFFFF,y=1 -> 0x0000 zr=1.
//  4 Back-to-back stream of 8 ops, then hold out_ready=0 for 5 cycles:
//    in_ready=0 after 2 more accepts, out stable; on release all 8 results arrive in order, none lost.
//  5 Reset mid-op: 2 ops in flight, pulse rst_n low between edges -> out_valid=0, out=0 immediately;
//    no stale result after release.
//  6 Bubbles: random in_valid/out_ready for 10k ops vs a reference model -> exact match, in order.

Source files
------------

// File: rtl/hack_alu_pipe.sv
// rtl/hack_alu_pipe.sv - two-stage valid/ready pipelined Hack-style ALU
// Stage 1 conditions the operands (zx/nx/zy/ny); stage 2 computes f/no and the zr/ng flags.
module hack_alu_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [5:0]       ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng
);

  logic             r_v1;
  logic [WIDTH-1:0] r_xp;
  logic [WIDTH-1:0] r_yp;
  logic             r_f;
  logic             r_no;

  logic             r_v2;
  logic [WIDTH-1:0] r_out;
  logic             r_zr;
  logic             r_ng;

  logic             w_s2_rdy;
  logic             w_s1_rdy;
  logic [WIDTH-1:0] w_xa;
  logic [WIDTH-1:0] w_xp;
  logic [WIDTH-1:0] w_ya;
  logic [WIDTH-1:0] w_yp;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_r;
  logic [WIDTH-1:0] w_res;

  // Ready depends only on occupancy and out_ready, never on in_valid.
  assign w_s2_rdy = !r_v2 || out_ready;
  assign w_s1_rdy = !r_v1 || w_s2_rdy;
  assign in_ready = w_s1_rdy;

  assign w_xa = ctrl[5] ? '0 : x;
  assign w_xp = ctrl[4] ? ~w_xa : w_xa;
  assign w_ya = ctrl[3] ? '0 : y;
  assign w_yp = ctrl[2] ? ~w_ya : w_ya;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1 <= 1'b0;
      r_xp <= '0;
      r_yp <= '0;
      r_f  <= 1'b0;
      r_no <= 1'b0;
    end else if (w_s1_rdy) begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_xp <= w_xp;
        r_yp <= w_yp;
        r_f  <= ctrl[1];
        r_no <= ctrl[0];
      end
    end
  end

  // Carry out of the add is dropped; the Hack ALU has no overflow flag.
  assign w_sum = r_xp + r_yp;
  assign w_r   = r_f ? w_sum : (r_xp & r_yp);
  assign w_res = r_no ? ~w_r : w_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2  <= 1'b0;
      r_out <= '0;
      r_zr  <= 1'b0;
      r_ng  <= 1'b0;
    end else if (w_s2_rdy) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_out <= w_res;
        r_zr  <= (w_res == '0);
        r_ng  <= w_res[WIDTH-1];
      end
    end
  end

  assign out_valid = r_v2;
  assign out       = r_out;
  assign zr        = r_zr;
  assign ng        = r_ng;

endmodule

// File: tb/tb_hack_alu_pipe.sv
// tb/tb_hack_alu_pipe.sv - self-checking bench for hack_alu_pipe against a queue-based model
module tb_hack_alu_pipe;
  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic [5:0]   ctrl;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] dout;
  logic         zr;
  logic         ng;

  hack_alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .ctrl(ctrl), .out_valid(out_valid), .out_ready(out_ready),
    .out(dout), .zr(zr), .ng(ng)
  );

  typedef struct {
    logic [W-1:0] o;
    logic         z;
    logic         n;
    int           c;
  } exp_t;

  exp_t           q[$];
  int             n_cmp = 0;
  int             n_fail = 0;
  int             cyc = 0;
  logic           stall_prev = 1'b0;
  logic [W+1:0]   stall_val = '0;
  logic           fired_in;
  logic           got;
  logic [W-1:0]   got_out;
  logic           got_zr;
  logic           got_ng;
  int             got_lat;

  function automatic exp_t ref_alu(input logic [W-1:0] a_in, input logic [W-1:0] b_in,
                                   input logic [5:0] c);
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
    exp_t e;
    a = c[5] ? '0 : a_in;
    if (c[4]) a = ~a;
    b = c[3] ? '0 : b_in;
    if (c[2]) b = ~b;
    r = c[1] ? (a + b) : (a & b);
    if (c[0]) r = ~r;
    e.o = r;
    e.z = (r == '0);
    e.n = r[W-1];
    e.c = 0;
    return e;
  endfunction

  function automatic logic [W-1:0] rnd_op();
    logic [W-1:0] corners [5];
    corners[0] = 16'h0000;
    corners[1] = 16'h0001;
    corners[2] = 16'h7FFF;
    corners[3] = 16'h8000;
    corners[4] = 16'hFFFF;
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
    return 16'($urandom);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // One cycle: inputs were driven just after the previous posedge; judge everything at negedge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    fired_in = 1'b0;
    check("in_ready", 32'(in_ready), 32'((q.size() < 2) || out_ready));
    if (stall_prev)
      check("stall_hold", 32'({out_valid, zr, ng, dout}), 32'({1'b1, stall_val}));
    if (out_valid) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL spurious_out: out_valid=1 out=0x%0h with nothing in flight (cycle %0d)", dout, cyc);
      end else if (out_ready) begin
        e = q.pop_front();
        check("result", 32'({zr, ng, dout}), 32'({e.z, e.n, e.o}));
        got     = 1'b1;
        got_out = dout;
        got_zr  = zr;
        got_ng  = ng;
        got_lat = cyc - e.c;
      end
    end
    if (in_valid && in_ready) begin
      e = ref_alu(x, y, ctrl);
      e.c = cyc;
      q.push_back(e);
      fired_in = 1'b1;
    end
    stall_prev = out_valid && !out_ready;
    stall_val  = {zr, ng, dout};
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input logic [W-1:0] xv, input logic [W-1:0] yv, input logic [5:0] cv,
                          input logic [W-1:0] eo, input logic ez, input logic en);
    got = 1'b0;
    x = xv;
    y = yv;
    ctrl = cv;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    check("lit_delivered", 32'(got), 32'(1));
    check("lit_out", 32'({got_zr, got_ng, got_out}), 32'({ez, en, eo}));
    check("lit_latency", 32'(got_lat), 32'(2));
  endtask

  initial begin
    logic [W-1:0] ox [8];
    logic [W-1:0] oy [8];
    logic [5:0]   oc [8];
    int idx;
    int n_del;
    int accepts;
    int guard;

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    x = '0;
    y = '0;
    ctrl = '0;
    got = 1'b0;
    got_out = '0;
    got_zr = 1'b0;
    got_ng = 1'b0;
    got_lat = 0;
    fired_in = 1'b0;

    @(posedge clk);
    #1;
    check("reset_out_valid", 32'(out_valid), 32'(0));
    check("reset_out", 32'({zr, ng, dout}), 32'(0));
    check("reset_in_ready", 32'(in_ready), 32'(1));
    rst_n = 1'b1;
    step();

    send_one(16'h0000, 16'h0000, 6'b101010, 16'h0000, 1'b1, 1'b0);
    send_one(16'h1234, 16'h5678, 6'b111111, 16'h0001, 1'b0, 1'b0);
    send_one(16'hABCD, 16'h0F0F, 6'b111010, 16'hFFFF, 1'b0, 1'b1);
    send_one(16'd5, 16'd3, 6'b000010, 16'd8, 1'b0, 1'b0);
    send_one(16'd5, 16'd3, 6'b010011, 16'd2, 1'b0, 1'b0);
    send_one(16'd5, 16'd3, 6'b000111, 16'hFFFE, 1'b0, 1'b1);
    send_one(16'd5, 16'd3, 6'b000000, 16'd1, 1'b0, 1'b0);
    send_one(16'd5, 16'd3, 6'b010101, 16'd7, 1'b0, 1'b0);
    send_one(16'h7FFF, 16'h0001, 6'b000010, 16'h8000, 1'b0, 1'b1);
    send_one(16'hFFFF, 16'h0001, 6'b000010, 16'h0000, 1'b1, 1'b0);

    // Stalled stream: only two of eight ops fit while out_ready is low.
    for (int i = 0; i < 8; i++) begin
      ox[i] = rnd_op();
      oy[i] = rnd_op();
      oc[i] = 6'($urandom);
    end
    idx = 0;
    n_del = 0;
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      x = ox[idx];
      y = oy[idx];
      ctrl = oc[idx];
      got = 1'b0;
      step();
      if (got) n_del++;
      if (fired_in) idx++;
    end
    check("full_accepts", 32'(idx), 32'(2));
    check("full_in_ready", 32'(in_ready), 32'(0));
    check("full_out_valid", 32'(out_valid), 32'(1));
    out_ready = 1'b1;
    guard = 0;
    while ((idx < 8 || q.size() > 0) && guard < 40) begin
      in_valid = (idx < 8);
      if (idx < 8) begin
        x = ox[idx];
        y = oy[idx];
        ctrl = oc[idx];
      end
      got = 1'b0;
      step();
      if (got) n_del++;
      if (fired_in) idx++;
      guard++;
    end
    in_valid = 1'b0;
    check("stream_delivered", 32'(n_del), 32'(8));

    // Reset with two ops in flight.
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1;
      x = rnd_op();
      y = rnd_op();
      ctrl = 6'b000010;
      step();
    end
    in_valid = 1'b0;
    check("pre_reset_valid", 32'(out_valid), 32'(1));
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_valid", 32'(out_valid), 32'(0));
    check("async_reset_out", 32'({zr, ng, dout}), 32'(0));
    q.delete();
    stall_prev = 1'b0;
    rst_n = 1'b1;
    got = 1'b0;
    repeat (4) step();
    check("no_stale_result", 32'(got), 32'(0));

    // Random bubbles on both sides.
    accepts = 0;
    guard = 0;
    while (accepts < 10000 && guard < 60000) begin
      in_valid = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      x = rnd_op();
      y = rnd_op();
      ctrl = 6'($urandom);
      step();
      if (fired_in) accepts++;
      guard++;
    end
    check("random_accepts", 32'(accepts), 32'(10000));
    in_valid = 1'b0;
    out_ready = 1'b1;
    guard = 0;
    while (q.size() > 0 && guard < 10) begin
      step();
      guard++;
    end
    check("drained", 32'(q.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
